// File: rtl/tb_axi_slave_mem_model.sv
// Memory-backed AXI4 slave model: stores write bursts, returns stored words on reads, echoes IDs, flags bad bursts.
// Define TB_AXI_SLAVE_STALL_EN for LFSR-driven back-pressure on WREADY/RVALID.
module tb_axi_slave_mem_model #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 1,
  parameter int unsigned MEM_AW     = 10,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [ID_W-1:0]     M_AXI_AWID,
  input  logic [ADDR_W-1:0]   M_AXI_AWADDR,
  input  logic [7:0]          M_AXI_AWLEN,
  input  logic [2:0]          M_AXI_AWSIZE,
  input  logic [1:0]          M_AXI_AWBURST,
  input  logic                M_AXI_AWVALID,
  output logic                M_AXI_AWREADY,
  input  logic [DATA_W-1:0]   M_AXI_WDATA,
  input  logic [DATA_W/8-1:0] M_AXI_WSTRB,
  input  logic                M_AXI_WLAST,
  input  logic                M_AXI_WVALID,
  output logic                M_AXI_WREADY,
  output logic [ID_W-1:0]     M_AXI_BID,
  output logic [1:0]          M_AXI_BRESP,
  output logic                M_AXI_BVALID,
  input  logic                M_AXI_BREADY,
  input  logic [ID_W-1:0]     M_AXI_ARID,
  input  logic [ADDR_W-1:0]   M_AXI_ARADDR,
  input  logic [7:0]          M_AXI_ARLEN,
  input  logic [2:0]          M_AXI_ARSIZE,
  input  logic [1:0]          M_AXI_ARBURST,
  input  logic                M_AXI_ARVALID,
  output logic                M_AXI_ARREADY,
  output logic [ID_W-1:0]     M_AXI_RID,
  output logic [DATA_W-1:0]   M_AXI_RDATA,
  output logic [1:0]          M_AXI_RRESP,
  output logic                M_AXI_RLAST,
  output logic                M_AXI_RVALID,
  input  logic                M_AXI_RREADY
);
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned DEPTH    = 2 ** MEM_AW;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic stall;
`ifdef TB_AXI_SLAVE_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr <= STALL_SEED;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Address bits above the word index are deliberately ignored (accesses wrap).
  logic unused;
  assign unused = ^{1'b0, STALL_SEED, M_AXI_AWADDR, M_AXI_ARADDR};

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic aw_bad, ar_bad;
  assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs  = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
  assign aw_bad = (M_AXI_AWBURST != BURST_FIXED && M_AXI_AWBURST != BURST_INCR) ||
                  (M_AXI_AWSIZE != 3'(ADDR_LSB));
  assign ar_bad = (M_AXI_ARBURST != BURST_FIXED && M_AXI_ARBURST != BURST_INCR) ||
                  (M_AXI_ARSIZE != 3'(ADDR_LSB));

  // ---------------- write channel ----------------
  logic [ID_W-1:0]   w_id;
  logic [MEM_AW-1:0] w_idx;
  logic [7:0]        w_len, w_beat;
  logic              w_fixed, w_bad, w_err, w_beat_err;
  logic [1:0]        b_resp;

  assign w_beat_err = M_AXI_WLAST ? (w_beat != w_len) : (w_beat == w_len);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        M_AXI_AWREADY = ARESETN;
        if (M_AXI_AWVALID && ARESETN) w_next = W_DATA;
      end
      W_DATA: begin
        M_AXI_WREADY = !stall;
        if (M_AXI_WVALID && !stall && M_AXI_WLAST) w_next = W_RESP;
      end
      W_RESP: begin
        M_AXI_BVALID = 1'b1;
        if (M_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_fixed <= 1'b0;
      w_bad   <= 1'b0;
      w_err   <= 1'b0;
      b_resp  <= '0;
    end else begin
      if (aw_hs) begin
        w_id    <= M_AXI_AWID;
        w_idx   <= M_AXI_AWADDR[ADDR_LSB +: MEM_AW];
        w_len   <= M_AXI_AWLEN;
        w_beat  <= '0;
        w_fixed <= (M_AXI_AWBURST == BURST_FIXED);
        w_bad   <= aw_bad;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        if (!w_fixed)   w_idx <= w_idx + MEM_AW'(1);
        if (w_beat_err) w_err <= 1'b1;
        if (M_AXI_WLAST) b_resp <= (w_bad || w_err || w_beat_err) ? RESP_SLVERR : 2'b00;
      end
    end
  end

  assign M_AXI_BID   = w_id;
  assign M_AXI_BRESP = b_resp;

  // ---------------- storage ----------------
  // One register per word so each can carry its own power-up value (mem[i] = i) without a reset.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  assign mem_we = w_hs && !w_bad;

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic [DATA_W-1:0] word = DATA_W'(g);
    always_ff @(posedge ACLK) begin
      if (mem_we && w_idx == MEM_AW'(g)) begin
        for (int unsigned k = 0; k < STRB_W; k++) begin
          if (M_AXI_WSTRB[k]) word[8*k +: 8] <= M_AXI_WDATA[8*k +: 8];
        end
      end
    end
    assign mem_q[g] = word;
  end

  // ---------------- read channel ----------------
  logic [ID_W-1:0]   r_id;
  logic [MEM_AW-1:0] r_idx;
  logic [7:0]        r_len, r_beat;
  logic              r_fixed, r_bad, r_last;

  assign r_last = (r_beat == r_len);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        M_AXI_ARREADY = ARESETN;
        if (M_AXI_ARVALID && ARESETN) r_next = R_DATA;
      end
      R_DATA: begin
        M_AXI_RVALID = !stall;
        if (!stall && M_AXI_RREADY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_fixed <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id    <= M_AXI_ARID;
        r_idx   <= M_AXI_ARADDR[ADDR_LSB +: MEM_AW];
        r_len   <= M_AXI_ARLEN;
        r_beat  <= '0;
        r_fixed <= (M_AXI_ARBURST == BURST_FIXED);
        r_bad   <= ar_bad;
      end
      if (r_hs) begin
        r_beat <= r_beat + 8'd1;
        if (!r_fixed) r_idx <= r_idx + MEM_AW'(1);
      end
    end
  end

  assign M_AXI_RID   = r_id;
  assign M_AXI_RDATA = (r_state == R_DATA && !r_bad) ? mem_q[r_idx] : '0;
  assign M_AXI_RRESP = (r_state == R_DATA && r_bad) ? RESP_SLVERR : 2'b00;
  assign M_AXI_RLAST = (r_state == R_DATA) && r_last;

endmodule

// File: tb/tb_tb_axi_slave_mem_model.sv
// Directed + randomized bench for tb_axi_slave_mem_model against a word-array reference model.
module tb_tb_axi_slave_mem_model;
  localparam int DEPTH = 1024;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  always #5 ACLK = ~ACLK;

  tb_axi_slave_mem_model #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .MEM_AW(10), .STALL_SEED(16'hACE1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID),
    .M_AXI_WREADY(WREADY), .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
    .M_AXI_BREADY(BREADY),
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    return ((int'(addr >> 2)) + (burst == INCR ? beat : 0)) % DEPTH;
  endfunction

  // Writes wdat/wstb[0..nbeats-1]; WLAST goes on the final beat regardless of len.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int nbeats,
                          input int bdelay);
    int n;
    logic bad_cmd;
    logic [1:0] exp_resp;
    int widx;
    bad_cmd  = (burst == WRAP) || (burst == RSVD) || (size != 3'd2);
    exp_resp = (bad_cmd || (nbeats - 1 != int'(len))) ? 2'b10 : 2'b00;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 200) begin @(negedge ACLK); n++; end
    check("aw_ready", AWREADY, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
`ifndef TB_AXI_SLAVE_STALL_EN
    check("wready_latency", WREADY, 1);
`endif
    for (int i = 0; i < nbeats; i++) begin
      WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == nbeats - 1); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 200) begin @(negedge ACLK); n++; end
      check("w_ready", WREADY, 1);
      if (!bad_cmd) begin
        widx = word_of(addr, burst, i);
        for (int k = 0; k < 4; k++)
          if (wstb[i][k]) model[widx][8*k +: 8] = wdat[i][8*k +: 8];
      end
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check("bvalid_latency", BVALID, 1);
    check("bid", BID, id);
    check("bresp", BRESP, exp_resp);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge ACLK);
      check("bvalid_hold", BVALID, 1);
      check("bid_hold", BID, id);
      check("awready_blocked", AWREADY, 0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_clear", BVALID, 0);
    check("awready_back", AWREADY, 1);
  endtask

  // abort_at >= 0 pulls ARESETN low while that beat is presented.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input bit rnd_ready,
                         input int abort_at);
    int n, beat;
    logic bad_cmd;
    bad_cmd = (burst == WRAP) || (burst == RSVD) || (size != 3'd2);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 200) begin @(negedge ACLK); n++; end
    check("ar_ready", ARREADY, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
`ifndef TB_AXI_SLAVE_STALL_EN
    check("rvalid_latency", RVALID, 1);
`endif
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 2000) begin
      RREADY = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (abort_at >= 0 && beat == abort_at && RVALID) begin
        ARESETN = 1'b0;
        #1;
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_awready", AWREADY, 0);
        RREADY = 1'b0;
        return;
      end
      if (RVALID && RREADY) begin
        check("rdata", RDATA, bad_cmd ? 32'h0 : model[word_of(addr, burst, beat)]);
        check("rresp", RRESP, bad_cmd ? 2'b10 : 2'b00);
        check("rlast", RLAST, beat == int'(len));
        check("rid", RID, id);
        beat++;
      end
      @(negedge ACLK);
      n++;
    end
    RREADY = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("rvalid_end", RVALID, 0);
    check("arready_back", ARREADY, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  b;
    logic [2:0]  s;
    int          nb, sel;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
    ARESETN = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    check("reset_awready", AWREADY, 0);
    check("reset_wready", WREADY, 0);
    check("reset_bvalid", BVALID, 0);
    check("reset_bid_bresp", {BID, BRESP}, 0);
    check("reset_arready", ARREADY, 0);
    check("reset_rvalid", RVALID, 0);
    check("reset_r_outs", {RID, RRESP, RLAST, RDATA}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    do_read(32'h0, 4'd5, 8'd3, INCR, 3'd2, 1'b0, -1);

    wdat[0] = 32'hDEADBEEF; wdat[1] = 32'h12345678; wstb[0] = 4'hF; wstb[1] = 4'hF;
    do_write(32'h40, 4'd1, 8'd1, INCR, 3'd2, 2, 0);
    do_read(32'h40, 4'd3, 8'd1, INCR, 3'd2, 1'b0, -1);

    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    do_write(32'h80, 4'd2, 8'd0, INCR, 3'd2, 1, 0);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    do_write(32'h80, 4'd2, 8'd0, INCR, 3'd2, 1, 0);
    do_read(32'h80, 4'd4, 8'd0, INCR, 3'd2, 1'b0, -1);

    for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(32'h100, 4'd3, 8'd3, INCR, 3'd2, 2, 1);
    do_write(32'h200, 4'd4, 8'd1, INCR, 3'd2, 3, 0);
    do_read(32'h100, 4'd6, 8'd3, WRAP, 3'd2, 1'b0, -1);
    do_read(32'h200, 4'd7, 8'd2, RSVD, 3'd2, 1'b0, -1);
    do_read(32'h100, 4'd8, 8'd1, INCR, 3'd1, 1'b0, -1);
    do_write(32'h140, 4'd9, 8'd1, WRAP, 3'd2, 2, 0);
    do_write(32'h148, 4'd10, 8'd0, INCR, 3'd3, 1, 0);
    do_read(32'h100, 4'd11, 8'd15, INCR, 3'd2, 1'b0, -1);

    do_write(32'h300, 4'd7, 8'd2, FIXED, 3'd2, 3, 5);
    do_read(32'h2FC, 4'd12, 8'd2, INCR, 3'd2, 1'b0, -1);
    do_write(32'h0FF8, 4'd13, 8'd3, INCR, 3'd2, 4, 0);
    do_read(32'h1FF8, 4'd14, 8'd3, INCR, 3'd2, 1'b1, -1);

    do_read(32'h40, 4'd9, 8'd7, INCR, 3'd2, 1'b0, 2);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    do_read(32'h40, 4'd10, 8'd1, INCR, 3'd2, 1'b0, -1);

    for (int t = 0; t < 30; t++) begin
      a   = 32'($urandom_range(0, 32'h3FFF));
      l   = 8'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      b   = (sel < 6) ? INCR : (sel < 8) ? FIXED : (sel == 8) ? WRAP : RSVD;
      s   = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : int'(l) + 1;
        for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
        do_write(a, 4'($urandom), l, b, s, nb, $urandom_range(0, 3));
      end else begin
        do_read(a, 4'($urandom), l, b, s, 1'b1, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
